rnn_step_sequencer: RTL and testbench

//  Drives the recurrent cell across a sequence of time steps: accepts x_t vectors over a valid/ready

---
 rtl/rnn_step_sequencer_pkg.sv | 10 +
 rtl/rnn_step_sequencer_if.sv | 34 +++
 rtl/rnn_step_sequencer_timer.sv | 27 ++
 rtl/rnn_step_sequencer.sv | 84 ++++++++
 tb/tb_rnn_step_sequencer.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/rnn_step_sequencer_pkg.sv
// rnn_pkg: shared defaults, Q3.4 unit constant and sequencer FSM states
package rnn_pkg;
  localparam int DW_DEF = 8;
  localparam int H_DEF = 4;
  localparam int X_DEF = 4;
  localparam int SEQ_LEN_DEF = 8;
  localparam int CELL_LAT_DEF = 6;
  localparam logic signed [7:0] Q_ONE = 8'sh10;
  typedef enum logic [1:0] {IDLE, WAIT, CAPT, EMIT} state_e;
endpackage

// File: rtl/rnn_step_sequencer_if.sv
// rnn_step_sequencer_if: x stream in, cell x/C_tp/H_tp -> C_t/H_t link, H_t stream out
// slave = sequencer view, master = environment view (feature buffer, cell, downstream).
// STATE_INIT_EN adds init_valid/init_c/init_h.
interface rnn_step_sequencer_if
  import rnn_pkg::*;
#(
  parameter int DATA_WIDTH = DW_DEF,
  parameter int H = H_DEF,
  parameter int X = X_DEF,
  parameter int SEQ_LEN = SEQ_LEN_DEF
);
  logic in_valid, in_ready, out_valid, out_ready, out_last;
  logic [X*DATA_WIDTH-1:0] in_x, cell_x;
  logic [H*DATA_WIDTH-1:0] cell_c, cell_h, cell_c_t, cell_h_t, out_h;
  logic [$clog2(SEQ_LEN+1)-1:0] step_idx;
`ifdef STATE_INIT_EN
  logic init_valid;
  logic [H*DATA_WIDTH-1:0] init_c, init_h;
`endif
  modport slave (
`ifdef STATE_INIT_EN
    input init_valid, init_c, init_h,
`endif
    input in_valid, in_x, cell_c_t, cell_h_t, out_ready,
    output in_ready, cell_x, cell_c, cell_h, out_valid, out_h, out_last, step_idx
  );
  modport master (
`ifdef STATE_INIT_EN
    output init_valid, init_c, init_h,
`endif
    output in_valid, in_x, cell_c_t, cell_h_t, out_ready,
    input in_ready, cell_x, cell_c, cell_h, out_valid, out_h, out_last, step_idx
  );
endinterface

// File: rtl/rnn_step_sequencer_timer.sv
// cell_wait_timer: start pulse -> done high while the count sits at CELL_LAT-1
// Ports: clk1, rst (sync, active-high), start_i, done_o.
module cell_wait_timer #(
  parameter int CELL_LAT = 6
) (
  input  logic clk1,
  input  logic rst,
  input  logic start_i,
  output logic done_o
);
  localparam int CW = $clog2(CELL_LAT + 1);
  logic [CW-1:0] cnt_q;
  logic active_q;
  assign done_o = active_q && cnt_q == CW'(CELL_LAT - 1);
  always_ff @(posedge clk1) begin
    if (rst) begin
      cnt_q <= '0;
      active_q <= 1'b0;
    end else if (start_i) begin
      cnt_q <= '0;
      active_q <= 1'b1;
    end else if (active_q) begin
      cnt_q <= done_o ? cnt_q : cnt_q + CW'(1);
      active_q <= !done_o;
    end
  end
endmodule

// File: rtl/rnn_step_sequencer.sv
// rnn_step_sequencer: steps the recurrent cell through SEQ_LEN time steps, holding C/H state
// Ports: clk1, rst (sync, active-high), bus (rnn_step_sequencer_if.slave).
// STATE_INIT_EN: init_valid in IDLE at step 0 loads init_c/init_h as the starting state.
module rnn_step_sequencer
  import rnn_pkg::*;
#(
  parameter int DATA_WIDTH = DW_DEF,
  parameter int H = H_DEF,
  parameter int X = X_DEF,
  parameter int SEQ_LEN = SEQ_LEN_DEF,
  parameter int CELL_LAT = CELL_LAT_DEF
) (
  input logic clk1,
  input logic rst,
  rnn_step_sequencer_if.slave bus
);
  localparam int SW = $clog2(SEQ_LEN + 1);
  state_e state_q;
  logic [X*DATA_WIDTH-1:0] x_q;
  logic [H*DATA_WIDTH-1:0] c_q, h_q, oh_q;
  logic ov_q, ol_q, done;
  logic [SW-1:0] step_q;
  wire last_step = step_q == SW'(SEQ_LEN - 1);
  cell_wait_timer #(.CELL_LAT(CELL_LAT)) u_timer (
    .clk1(clk1),
    .rst(rst),
    .start_i(state_q == IDLE && bus.in_valid),
    .done_o(done)
  );
  assign bus.in_ready = state_q == IDLE;
  assign bus.cell_x = x_q;
  assign bus.cell_c = c_q;
  assign bus.cell_h = h_q;
  assign bus.out_h = oh_q;
  assign bus.out_valid = ov_q;
  assign bus.out_last = ol_q;
  assign bus.step_idx = step_q;
  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q <= IDLE;
      x_q <= '0;
      c_q <= '0;
      h_q <= '0;
      oh_q <= '0;
      ov_q <= 1'b0;
      ol_q <= 1'b0;
      step_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
`ifdef STATE_INIT_EN
          if (bus.init_valid && step_q == '0) begin
            c_q <= bus.init_c;
            h_q <= bus.init_h;
          end
`endif
          if (bus.in_valid) begin
            x_q <= bus.in_x;
            state_q <= WAIT;
          end
        end
        WAIT: state_q <= done ? CAPT : WAIT;
        CAPT: begin
          c_q <= bus.cell_c_t;
          h_q <= bus.cell_h_t;
          oh_q <= bus.cell_h_t;
          ov_q <= 1'b1;
          ol_q <= last_step;
          state_q <= EMIT;
        end
        EMIT: if (bus.out_ready) begin
          ov_q <= 1'b0;
          state_q <= IDLE;
          step_q <= last_step ? '0 : step_q + SW'(1);
          if (last_step) begin
            c_q <= '0;
            h_q <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rnn_step_sequencer.sv
// tb_rnn_step_sequencer: directed and random checks of rnn_step_sequencer against a recurrence model
module tb_rnn_step_sequencer;
  localparam int SEQ = 3;
  localparam int LAT = 6;
  logic clk1 = 1'b0, rst = 1'b1, ident = 1'b1;
  int n_chk = 0, n_err = 0, cyc = 0;
  always #5 clk1 = ~clk1;
  always @(posedge clk1) cyc++;
  rnn_step_sequencer_if #(.DATA_WIDTH(8), .H(4), .X(4), .SEQ_LEN(SEQ)) b ();
  rnn_step_sequencer #(.DATA_WIDTH(8), .H(4), .X(4), .SEQ_LEN(SEQ), .CELL_LAT(LAT)) dut (
    .clk1(clk1),
    .rst(rst),
    .bus(b)
  );
  function automatic logic [31:0] fc(logic [31:0] x, logic [31:0] c);
    return ident ? x : x + c;
  endfunction
  function automatic logic [31:0] fh(logic [31:0] x, logic [31:0] c, logic [31:0] h);
    return ident ? x : x ^ fc(x, c) ^ {h[23:0], h[31:24]};
  endfunction
  assign b.cell_c_t = fc(b.cell_x, b.cell_c);
  assign b.cell_h_t = fh(b.cell_x, b.cell_c, b.cell_h);
`ifdef STATE_INIT_EN
  assign b.init_valid = 1'b0;
  assign b.init_c = '0;
  assign b.init_h = '0;
`endif
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask
  // Model: the sequence recurrence (c,h) <- cell(x,c,h), zeroed after the last step.
  logic [31:0] c_m, h_m, cur_x, cur_c, cur_h, q_h[$];
  bit q_l[$];
  int s_m, cur_s, acc_cyc;
  bit ov_prev;
  always @(negedge clk1) begin
    if (rst) begin
      c_m = 0; h_m = 0; s_m = 0; cur_s = 0;
      q_h.delete(); q_l.delete(); ov_prev = 0;
    end else begin
      if (b.in_ready) begin
        chk("idle_c", b.cell_c, c_m);
        chk("idle_h", b.cell_h, h_m);
        chk("idle_step", 32'(b.step_idx), 32'(s_m));
        chk("idle_ov", 32'(b.out_valid), 0);
        if (b.in_valid) begin
          cur_x = b.in_x; cur_c = c_m; cur_h = h_m; cur_s = s_m;
          c_m = fc(cur_x, cur_c);
          h_m = fh(cur_x, cur_c, cur_h);
          q_h.push_back(h_m);
          q_l.push_back(s_m == SEQ - 1);
          if (s_m == SEQ - 1) begin c_m = 0; h_m = 0; s_m = 0; end
          else s_m++;
          acc_cyc = cyc;
        end
      end else if (!b.out_valid) begin
        chk("wait_x", b.cell_x, cur_x);
        chk("wait_c", b.cell_c, cur_c);
        chk("wait_h", b.cell_h, cur_h);
        chk("wait_step", 32'(b.step_idx), 32'(cur_s));
      end else if (q_h.size() == 0) begin
        chk("spurious_out", 32'(b.out_valid), 0);
      end else begin
        // accept edge is one after the sampling negedge, hence +1 on top of LAT+1
        if (!ov_prev) chk("latency", 32'(cyc - acc_cyc), 32'(LAT + 2));
        chk("out_h", b.out_h, q_h[0]);
        chk("out_last", 32'(b.out_last), 32'(q_l[0]));
        chk("emit_cell_h", b.cell_h, q_h[0]);
        chk("emit_step", 32'(b.step_idx), 32'(cur_s));
        if (b.out_ready) begin void'(q_h.pop_front()); void'(q_l.pop_front()); end
      end
      ov_prev = b.out_valid;
    end
  end
  task automatic send(input logic [31:0] x);
    int n = 0;
    @(posedge clk1); #1;
    b.in_valid = 1; b.in_x = x;
    do begin @(negedge clk1); n++; end while (!b.in_ready && n < 50);
    if (!b.in_ready) chk("accept_timeout", 0, 1);
    @(posedge clk1); #1;
    b.in_valid = 0;
  endtask
  task automatic wait_ov();
    int n = 0;
    do begin @(negedge clk1); n++; end while (!b.out_valid && n < 50);
    if (!b.out_valid) chk("out_timeout", 0, 1);
  endtask
  task automatic step(input logic [31:0] x, input logic last);
    send(x);
    wait_ov();
    chk("lit_out_h", b.out_h, x);
    chk("lit_last", 32'(b.out_last), 32'(last));
    @(posedge clk1); #1;
  endtask
  initial begin
    b.in_valid = 0; b.in_x = 0; b.out_ready = 1;
    repeat (3) @(posedge clk1);
    #1 rst = 0;
    @(negedge clk1);
    chk("rst_in_ready", 32'(b.in_ready), 1);
    chk("rst_out_valid", 32'(b.out_valid), 0);
    chk("rst_cell_c", b.cell_c, 0);
    chk("rst_cell_h", b.cell_h, 0);
    chk("rst_step", 32'(b.step_idx), 0);
    step(32'h10203040, 0);
    @(negedge clk1);
    chk("next_cell_h", b.cell_h, 32'h10203040);
    chk("next_step", 32'(b.step_idx), 1);
    step(32'h0a0b0c0d, 0);
    step(32'h11223344, 1);
    @(negedge clk1);
    chk("wrap_step", 32'(b.step_idx), 0);
    chk("wrap_c", b.cell_c, 0);
    chk("wrap_h", b.cell_h, 0);
    b.out_ready = 0;
    send(32'h55667788);
    wait_ov();
    for (int i = 0; i < 10; i++) begin
      @(posedge clk1); #1;
      b.in_valid = ~b.in_valid; b.in_x = $urandom;
      @(negedge clk1);
      chk("bp_valid", 32'(b.out_valid), 1);
      chk("bp_out_h", b.out_h, 32'h55667788);
      chk("bp_last", 32'(b.out_last), 0);
      chk("bp_in_ready", 32'(b.in_ready), 0);
    end
    @(posedge clk1); #1;
    b.in_valid = 0; b.out_ready = 1;
    @(posedge clk1);
    send(32'h99aabbcc);
    repeat (3) @(posedge clk1);
    #1 rst = 1;
    @(posedge clk1); #1 rst = 0;
    @(negedge clk1);
    chk("mid_rst_in_ready", 32'(b.in_ready), 1);
    chk("mid_rst_ov", 32'(b.out_valid), 0);
    chk("mid_rst_last", 32'(b.out_last), 0);
    chk("mid_rst_x", b.cell_x, 0);
    chk("mid_rst_c", b.cell_c, 0);
    chk("mid_rst_h", b.cell_h, 0);
    chk("mid_rst_out_h", b.out_h, 0);
    chk("mid_rst_step", 32'(b.step_idx), 0);
    ident = 0;
    for (int i = 0; i < 600; i++) begin
      @(posedge clk1); #1;
      b.in_valid = ($urandom % 3) != 0;
      b.in_x = $urandom;
      b.out_ready = ($urandom % 4) != 0;
    end
    @(posedge clk1); #1;
    b.in_valid = 0; b.out_ready = 1;
    repeat (LAT + 5) @(posedge clk1);
    @(negedge clk1);
    chk("drain", 32'(q_h.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
